// File: rtl/dm_axi_if.sv
// AXI4 subset used by the data-memory master: single-beat AR/R and AW/W/B.
interface dm_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RDATA, RRESP, RLAST, RVALID, output RREADY,
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY,
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/dm_axi_master.sv
// Data-memory AXI4 master for the 5-stage CPU. Turns a MEM-stage load/store
// into one single-beat AXI transaction, stalls the pipeline until it finishes,
// and holds the result in DONE until the pipeline really advances.
// Optional: define DM_TIMEOUT_EN to add a watchdog that forces DONE with an
// error after TIMEOUT_CYCLES busy cycles.
module dm_axi_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                DM_req,
  input  logic                DM_we,
  input  logic [ADDR_W-1:0]   DM_addr,
  input  logic [DATA_W-1:0]   DM_wdata,
  input  logic [DATA_W/8-1:0] DM_wstrb,
  input  logic                pipe_adv,
  output logic                DM_stall,
  output logic [DATA_W-1:0]   DM_rdata,
  output logic                DM_err,
  dm_axi_if.master            axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                busy;
  logic                aw_ok, w_ok;
  logic                unused_rlast;
`ifdef DM_TIMEOUT_EN
  logic [7:0]          cnt_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign busy = (state_q == S_RADDR) || (state_q == S_RDATA) ||
                (state_q == S_WREQ)  || (state_q == S_WRESP);

  // Stall covers the request cycle in IDLE and every bus-wait state, never DONE.
  assign DM_stall = ((state_q == S_IDLE) && DM_req) || busy;

  // Each write channel counts as done once its valid is gone or being accepted.
  assign aw_ok = !awvalid_q || axi.AWREADY;
  assign w_ok  = !wvalid_q  || axi.WREADY;

  // FSM with registered valid/ready outputs and the latched request.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef DM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DM_req) begin
            addr_q  <= DM_addr;
            wdata_q <= DM_wdata;
            wstrb_q <= DM_wstrb;
            if (DM_we) begin
              state_q   <= S_WREQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_RADDR: begin
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (axi.RVALID) begin
            rdata_q  <= axi.RDATA;
            err_q    <= |axi.RRESP;
            rready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_WREQ: begin
          if (awvalid_q && axi.AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q  && axi.WREADY)  wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (axi.BVALID) begin
            err_q    <= |axi.BRESP;
            bready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // Result stays put until the MEM/WB register actually loads it.
          if (pipe_adv) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef DM_TIMEOUT_EN
      // Watchdog overrides any handshake decided above in the same cycle.
      if (busy) begin
        if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_q   <= S_DONE;
          err_q     <= 1'b1;
          rdata_q   <= '0;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

  assign DM_rdata = rdata_q;
  assign DM_err   = err_q;

  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 8'd0;
  assign axi.ARSIZE  = 3'($clog2(DATA_W/8));
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 8'd0;
  assign axi.AWSIZE  = 3'($clog2(DATA_W/8));
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = wvalid_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;

  // Single-beat reads: the last-beat flag carries no extra information.
  assign unused_rlast = axi.RLAST;

endmodule
